// File: rtl/control_sequencer.sv
// control_sequencer
//   Multi-cycle fetch/decode/execute controller for the ALU datapath.
//   FETCH presents pc to a synchronous instruction memory, DECODE latches the
//   returned word into ir and advances pc, EXEC issues the instruction's
//   strobes, and MEM covers the extra read-data cycle of the memory loads.
//   HLT parks the sequencer in HALT until reset.
// Ports:
//   clk                      system clock (rising edge)
//   reset_control_sequencer  synchronous active-high reset
//   run                      permits leaving FETCH
//   imem_data                instruction word, valid the cycle after imem_addr
//   alu_r                    datapath result R, source of STR
//   imem_addr                fetch address (= pc)
//   opcode / ir_operand      ir[15:12] / ir[7:0] to the datapath
//   cu_A / cu_B              operand selects: 00 hold, 10 dmem, 11 immediate
//   RER                      result-register enable pulse
//   dmem_addr/we/wdata       data memory interface
//   halted                   high in HALT
module control_sequencer #(
  parameter int                   PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset_control_sequencer,
  input  logic                run,
  input  logic [15:0]         imem_data,
  input  logic [7:0]          alu_r,
  output logic [PC_WIDTH-1:0] imem_addr,
  output logic [3:0]          opcode,
  output logic [7:0]          ir_operand,
  output logic [1:0]          cu_A,
  output logic [1:0]          cu_B,
  output logic                RER,
  output logic [7:0]          dmem_addr,
  output logic                dmem_we,
  output logic [7:0]          dmem_wdata,
  output logic                halted
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_LDAI = 4'h6;
  localparam logic [3:0] OP_LDAM = 4'h7;
  localparam logic [3:0] OP_LDBI = 4'h8;
  localparam logic [3:0] OP_LDBM = 4'h9;
  localparam logic [3:0] OP_STR  = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_HLT  = 4'hF;

  state_t              state;
  logic [PC_WIDTH-1:0] pc;
  logic [15:0]         ir;

  // ir[11:8] is reserved in the instruction format and never decoded.
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir[11:8];

  always_ff @(posedge clk) begin
    if (reset_control_sequencer) begin
      state <= S_FETCH;
      pc    <= RESET_PC;
      ir    <= '0;
    end else begin
      case (state)
        S_FETCH:  if (run) state <= S_DECODE;
        S_DECODE: begin
          ir    <= imem_data;
          pc    <= pc + 1'b1;          // natural wrap at 2^PC_WIDTH
          state <= S_EXEC;
        end
        S_EXEC: begin
          case (ir[15:12])
            OP_LDAM, OP_LDBM: state <= S_MEM;
            OP_HLT:           state <= S_HALT;
            OP_JMP: begin
              pc    <= PC_WIDTH'(ir[7:0]);   // overrides the DECODE increment
              state <= S_FETCH;
            end
            default:          state <= S_FETCH;
          endcase
        end
        S_MEM:    state <= S_FETCH;
        S_HALT:   state <= S_HALT;
        default:  state <= S_FETCH;
      endcase
    end
  end

  // Moore decode of state/ir. Everything is forced low while reset is high so
  // no strobe escapes on the cycle reset is sampled.
  always_comb begin
    imem_addr  = '0;
    opcode     = 4'h0;
    ir_operand = 8'h00;
    cu_A       = 2'b00;
    cu_B       = 2'b00;
    RER        = 1'b0;
    dmem_addr  = 8'h00;
    dmem_we    = 1'b0;
    dmem_wdata = 8'h00;
    halted     = 1'b0;
    if (!reset_control_sequencer) begin
      imem_addr  = pc;
      opcode     = ir[15:12];
      ir_operand = ir[7:0];
      case (state)
        S_EXEC: begin
          case (ir[15:12])
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: RER = 1'b1;
            OP_LDAI: cu_A = 2'b11;
            OP_LDBI: cu_B = 2'b11;
            OP_LDAM, OP_LDBM: dmem_addr = ir[7:0];
            OP_STR: begin
              dmem_we    = 1'b1;
              dmem_addr  = ir[7:0];
              dmem_wdata = alu_r;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          // read data returned by dmem is valid now; select it into A or B
          dmem_addr = ir[7:0];
          if (ir[15:12] == OP_LDAM) cu_A = 2'b10;
          if (ir[15:12] == OP_LDBM) cu_B = 2'b10;
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer with synchronous imem/dmem models and a
// small A/B/R datapath model attached to the sequencer outputs.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [15:0] imem_data;
  logic [7:0]  alu_r;
  logic [7:0]  imem_addr;
  logic [3:0]  opcode;
  logic [7:0]  ir_operand;
  logic [1:0]  cu_A, cu_B;
  logic        RER;
  logic [7:0]  dmem_addr;
  logic        dmem_we;
  logic [7:0]  dmem_wdata;
  logic        halted;

  int errors = 0;
  int checks = 0;

  control_sequencer #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset_control_sequencer(rst), .run(run),
    .imem_data(imem_data), .alu_r(alu_r),
    .imem_addr(imem_addr), .opcode(opcode), .ir_operand(ir_operand),
    .cu_A(cu_A), .cu_B(cu_B), .RER(RER),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wdata(dmem_wdata),
    .halted(halted)
  );

  always #5 clk = ~clk;

  // environment: synchronous memories and datapath registers
  logic [15:0] imem [0:255];
  logic [7:0]  dmem [0:255];
  logic [7:0]  dmem_q;
  logic [7:0]  ra, rb, rr;
  int          rer_cnt = 0;
  int          we_cnt  = 0;

  assign alu_r = rr;

  always @(posedge clk) begin
    imem_data <= imem[imem_addr];
    dmem_q    <= dmem[dmem_addr];
    if (dmem_we) dmem[dmem_addr] <= dmem_wdata;
    if (RER)     rer_cnt <= rer_cnt + 1;
    if (dmem_we) we_cnt  <= we_cnt + 1;
    if (rst) begin
      ra <= 8'h00; rb <= 8'h00; rr <= 8'h00;
    end else begin
      if (cu_A == 2'b11) ra <= ir_operand;
      if (cu_A == 2'b10) ra <= dmem_q;
      if (cu_B == 2'b11) rb <= ir_operand;
      if (cu_B == 2'b10) rb <= dmem_q;
      if (RER) begin
        case (opcode)
          4'h1: rr <= ra + rb;
          4'h2: rr <= ra - rb;
          4'h3: rr <= ra & rb;
          4'h4: rr <= ra | rb;
          4'h5: rr <= ra ^ rb;
          default: ;
        endcase
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      imem[i] = 16'h0000;
      dmem[i] = 8'h00;
    end
  endtask

  // leaves reset released at a negedge with the sequencer in FETCH
  task automatic do_reset(input logic run_val);
    rst = 1'b1;
    run = run_val;
    step(2);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    clear_mem();
    rst = 1'b1;
    run = 1'b1;
    step(2);
    checks++;
    if ({imem_addr, opcode, ir_operand, cu_A, cu_B, RER, dmem_addr, dmem_we, dmem_wdata, halted} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got imem_addr=%h op=%h opr=%h cuA=%b cuB=%b RER=%b dma=%h we=%b wd=%h halted=%b expected all 0",
               imem_addr, opcode, ir_operand, cu_A, cu_B, RER, dmem_addr, dmem_we, dmem_wdata, halted);
    end
    run = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (imem_addr !== 8'h00 || opcode !== 4'h0 || ir_operand !== 8'h00) begin
      errors++;
      $display("FAIL reset_release: got pc=%h op=%h opr=%h expected 00/0/00", imem_addr, opcode, ir_operand);
    end
  endtask

  // LDAI 5 / LDBI 3 / ADD; expected R = 8, 9 cycles from first FETCH
  task automatic test_alu();
    int r0;
    clear_mem();
    imem[8'h00] = 16'h6005;
    imem[8'h01] = 16'h8003;
    imem[8'h02] = 16'h1000;
    imem[8'h03] = 16'h7010;
    imem[8'h04] = 16'hA020;
    imem[8'h05] = 16'hC040;
    imem[8'h40] = 16'hB0FF;
    imem[8'h41] = 16'hC0FF;
    imem[8'hFF] = 16'h0000;
    dmem[8'h10] = 8'hAA;
    do_reset(1'b1);
    r0 = rer_cnt;
    step(2);                               // N2: LDAI EXEC
    checks++;
    if (cu_A !== 2'b11 || ir_operand !== 8'h05 || cu_B !== 2'b00) begin
      errors++;
      $display("FAIL ldai_exec: got cuA=%b cuB=%b opr=%h expected 11/00/05", cu_A, cu_B, ir_operand);
    end
    step(3);                               // N5: LDBI EXEC
    checks++;
    if (cu_B !== 2'b11 || ir_operand !== 8'h03 || cu_A !== 2'b00) begin
      errors++;
      $display("FAIL ldbi_exec: got cuA=%b cuB=%b opr=%h expected 00/11/03", cu_A, cu_B, ir_operand);
    end
    step(2);                               // N7: ADD DECODE, no pulse yet
    checks++;
    if (RER !== 1'b0) begin
      errors++;
      $display("FAIL add_decode_rer: got %b expected 0", RER);
    end
    step(1);                               // N8: ADD EXEC
    checks++;
    if (opcode !== 4'h1 || RER !== 1'b1) begin
      errors++;
      $display("FAIL add_exec: got op=%h RER=%b expected 1/1", opcode, RER);
    end
    step(1);                               // N9: FETCH of pc 3
    checks++;
    if (RER !== 1'b0 || rer_cnt - r0 !== 1 || alu_r !== 8'h08 || imem_addr !== 8'h03) begin
      errors++;
      $display("FAIL add_result: got RER=%b pulses=%0d R=%h pc=%h expected 0/1/08/03",
               RER, rer_cnt - r0, alu_r, imem_addr);
    end
  endtask

  task automatic test_ldam();
    step(2);                               // N11: LDAM EXEC
    checks++;
    if (dmem_addr !== 8'h10 || cu_A !== 2'b00 || dmem_we !== 1'b0) begin
      errors++;
      $display("FAIL ldam_exec: got dma=%h cuA=%b we=%b expected 10/00/0", dmem_addr, cu_A, dmem_we);
    end
    step(1);                               // N12: MEM
    checks++;
    if (cu_A !== 2'b10 || cu_B !== 2'b00 || dmem_addr !== 8'h10) begin
      errors++;
      $display("FAIL ldam_mem: got cuA=%b cuB=%b dma=%h expected 10/00/10", cu_A, cu_B, dmem_addr);
    end
    step(1);                               // N13: FETCH of pc 4 -> 4 cycles
    checks++;
    if (imem_addr !== 8'h04 || cu_A !== 2'b00 || ra !== 8'hAA) begin
      errors++;
      $display("FAIL ldam_done: got pc=%h cuA=%b A=%h expected 04/00/AA", imem_addr, cu_A, ra);
    end
  endtask

  task automatic test_str();
    int w0;
    w0 = we_cnt;
    step(1);                               // N14: DECODE
    checks++;
    if (dmem_we !== 1'b0) begin
      errors++;
      $display("FAIL str_decode_we: got %b expected 0", dmem_we);
    end
    step(1);                               // N15: EXEC
    checks++;
    if (dmem_we !== 1'b1 || dmem_addr !== 8'h20 || dmem_wdata !== 8'h08) begin
      errors++;
      $display("FAIL str_exec: got we=%b dma=%h wd=%h expected 1/20/08", dmem_we, dmem_addr, dmem_wdata);
    end
    step(1);                               // N16: FETCH of pc 5
    checks++;
    if (dmem_we !== 1'b0 || we_cnt - w0 !== 1 || dmem[8'h20] !== 8'h08 || imem_addr !== 8'h05) begin
      errors++;
      $display("FAIL str_done: got we=%b pulses=%0d mem=%h pc=%h expected 0/1/08/05",
               dmem_we, we_cnt - w0, dmem[8'h20], imem_addr);
    end
  endtask

  task automatic test_jmp();
    step(3);                               // N19: FETCH after JMP 40
    checks++;
    if (imem_addr !== 8'h40) begin
      errors++;
      $display("FAIL jmp_target: got %h expected 40", imem_addr);
    end
  endtask

  task automatic test_opcode_b();
    int r0, w0;
    r0 = rer_cnt;
    w0 = we_cnt;
    step(2);                               // N21: EXEC of B0FF
    checks++;
    if (opcode !== 4'hB || cu_A !== 2'b00 || cu_B !== 2'b00 || RER !== 1'b0 || dmem_we !== 1'b0) begin
      errors++;
      $display("FAIL opb_exec: got op=%h cuA=%b cuB=%b RER=%b we=%b expected B/00/00/0/0",
               opcode, cu_A, cu_B, RER, dmem_we);
    end
    step(1);                               // N22: FETCH of pc 41
    checks++;
    if (imem_addr !== 8'h41 || rer_cnt !== r0 || we_cnt !== w0) begin
      errors++;
      $display("FAIL opb_done: got pc=%h rer=%0d we=%0d expected 41/%0d/%0d",
               imem_addr, rer_cnt - r0, we_cnt - w0, 0, 0);
    end
  endtask

  task automatic test_wrap();
    step(3);                               // N25: FETCH at FF
    checks++;
    if (imem_addr !== 8'hFF) begin
      errors++;
      $display("FAIL jmp_ff: got %h expected FF", imem_addr);
    end
    step(3);                               // N28: after NOP at FF
    checks++;
    if (imem_addr !== 8'h00) begin
      errors++;
      $display("FAIL pc_wrap: got %h expected 00", imem_addr);
    end
  endtask

  task automatic test_halt();
    int r0, w0, bad;
    clear_mem();
    imem[8'h00] = 16'hF000;
    do_reset(1'b1);
    step(2);                               // N2: EXEC of HLT
    checks++;
    if (halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_early: got %b expected 0", halted);
    end
    step(1);                               // N3: HALT
    checks++;
    if (halted !== 1'b1 || imem_addr !== 8'h01) begin
      errors++;
      $display("FAIL halt_enter: got halted=%b pc=%h expected 1/01", halted, imem_addr);
    end
    r0 = rer_cnt;
    w0 = we_cnt;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (halted !== 1'b1 || imem_addr !== 8'h01 || RER !== 1'b0 || dmem_we !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || rer_cnt !== r0 || we_cnt !== w0) begin
      errors++;
      $display("FAIL halt_hold: got bad_cycles=%0d rer=%0d we=%0d expected 0/0/0",
               bad, rer_cnt - r0, we_cnt - w0);
    end
  endtask

  task automatic test_run_low();
    int r0, bad;
    clear_mem();
    imem[8'h00] = 16'h1000;
    do_reset(1'b0);
    r0 = rer_cnt;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (imem_addr !== 8'h00 || opcode !== 4'h0 || RER !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || rer_cnt !== r0) begin
      errors++;
      $display("FAIL run_low_hold: got bad_cycles=%0d rer=%0d expected 0/0", bad, rer_cnt - r0);
    end
    run = 1'b1;
    step(2);                               // DECODE, then EXEC
    run = 1'b0;                            // dropping run mid-instruction must not stall
    #1;
    checks++;
    if (opcode !== 4'h1 || RER !== 1'b1) begin
      errors++;
      $display("FAIL run_resume: got op=%h RER=%b expected 1/1", opcode, RER);
    end
  endtask

  task automatic test_reset_mid();
    int w0;
    clear_mem();
    imem[8'h00] = 16'hA020;
    dmem[8'h20] = 8'h55;
    do_reset(1'b1);
    step(2);                               // EXEC of STR
    checks++;
    if (dmem_we !== 1'b1) begin
      errors++;
      $display("FAIL rmid_pre: got we=%b expected 1", dmem_we);
    end
    w0 = we_cnt;
    rst = 1'b1;
    run = 1'b0;
    #1;
    checks++;
    if (dmem_we !== 1'b0 || dmem_addr !== 8'h00 || RER !== 1'b0) begin
      errors++;
      $display("FAIL rmid_gate: got we=%b dma=%h RER=%b expected 0/00/0", dmem_we, dmem_addr, RER);
    end
    step(1);
    rst = 1'b0;
    #1;
    checks++;
    if (imem_addr !== 8'h00 || opcode !== 4'h0 || ir_operand !== 8'h00 || dmem_we !== 1'b0 ||
        we_cnt !== w0 || dmem[8'h20] !== 8'h55) begin
      errors++;
      $display("FAIL rmid_after: got pc=%h op=%h opr=%h we=%b pulses=%0d mem=%h expected 00/0/00/0/0/55",
               imem_addr, opcode, ir_operand, dmem_we, we_cnt - w0, dmem[8'h20]);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_ldam();
    test_str();
    test_jmp();
    test_opcode_b();
    test_wrap();
    test_halt();
    test_run_low();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
